// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit. It sits next to the single-cycle ALU in
// the execute stage. The core issues an operation with a one-cycle start pulse
// and stalls while busy is high. It collects md_result on the one-cycle done
// pulse.
//
// Every operation takes the same number of cycles:
//   start sampled at edge k -> busy high after edges k .. k+V
//                            -> done high after edge k+V+1
//
// Multiply uses unsigned shift-add on operand magnitudes and negates the
// product at the end. Divide uses a restoring algorithm on magnitudes and
// fixes the signs at the end. The special cases (divide by zero and signed
// overflow) are detected when the operands are captured. They are applied in
// the final cycle, so the latency does not change.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   issue strobe, sampled only while idle
//   md_ctrl    in   [2:0] RV32M funct3
//                   (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   src_a      in   [V-1:0] rs1 (multiplicand / dividend)
//   src_b      in   [V-1:0] rs2 (multiplier / divisor)
//   busy       out  operation in flight
//   done       out  one-cycle result strobe
//   md_result  out  [V-1:0] registered result, held until the next done
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int V = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   md_ctrl,
    input  logic [V-1:0] src_a,
    input  logic [V-1:0] src_b,
    output logic         busy,
    output logic         done,
    output logic [V-1:0] md_result
);

    localparam int CNT_W = $clog2(V + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]     op_q;       // captured md_ctrl
    logic           qneg_q;     // product / quotient must be negated
    logic           rneg_q;     // remainder must be negated (dividend sign)
    logic           dz_q;       // divide by zero
    logic           ovf_q;      // signed divide overflow
    logic [V-1:0]   opnd_q;     // multiplicand magnitude or divisor magnitude
    logic [V-1:0]   hi_q;       // product high half / partial remainder
    logic [V-1:0]   lo_q;       // multiplier -> product low half, or dividend -> quotient
    logic           busy_q;
    logic           done_q;
    logic [V-1:0]   result_q;

    // -------------------------------------------------------------------------
    // Operand capture decode (used only in the start cycle)
    // -------------------------------------------------------------------------
    logic         cap_is_div;
    logic         cap_a_signed;
    logic         cap_b_signed;
    logic         cap_a_neg;
    logic         cap_b_neg;
    logic [V-1:0] cap_a_mag;
    logic [V-1:0] cap_b_mag;
    logic         cap_dz;
    logic         cap_ovf;

    // NOTE: every signal written in always_comb gets a default at the top of
    // the block, so no path through the block can leave it unassigned. An
    // unassigned path would infer a latch.
    always_comb begin
        cap_is_div   = md_ctrl[2];
        cap_a_signed = 1'b0;
        cap_b_signed = 1'b0;
        if (cap_is_div) begin
            // DIV and REM are signed; DIVU and REMU have funct3[0] set.
            cap_a_signed = ~md_ctrl[0];
            cap_b_signed = ~md_ctrl[0];
        end else begin
            // MULH takes both operands as signed. MULHSU takes only rs1 as
            // signed. MUL is treated as unsigned, which is safe because the
            // low half of the product does not depend on signedness.
            cap_a_signed = (md_ctrl[1:0] == 2'b01) || (md_ctrl[1:0] == 2'b10);
            cap_b_signed = (md_ctrl[1:0] == 2'b01);
        end
        cap_a_neg = cap_a_signed & src_a[V-1];
        cap_b_neg = cap_b_signed & src_b[V-1];
        cap_a_mag = cap_a_neg ? (~src_a + 1'b1) : src_a;
        cap_b_mag = cap_b_neg ? (~src_b + 1'b1) : src_b;
        cap_dz    = cap_is_div && (src_b == '0);
        cap_ovf   = cap_is_div && cap_a_signed &&
                    (src_a == {1'b1, {(V-1){1'b0}}}) && (src_b == '1);
    end

    // -------------------------------------------------------------------------
    // One iteration of shift-add multiply or restoring divide
    // -------------------------------------------------------------------------
    logic [V:0]   mul_sum;
    logic [V:0]   div_shift;
    logic [V:0]   div_diff;
    logic [V-1:0] hi_d;
    logic [V-1:0] lo_d;

    always_comb begin
        mul_sum   = '0;
        div_shift = '0;
        div_diff  = '0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (!op_q[2]) begin
            // Add the multiplicand when the multiplier LSB is set, then shift
            // the whole {carry, hi, lo} right by one. The multiplier bits
            // leave lo as the product bits move in.
            mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(V+1){1'b0}});
            hi_d    = mul_sum[V:1];
            lo_d    = {mul_sum[0], lo_q[V-1:1]};
        end else begin
            // Shift the next dividend bit into the remainder and try the
            // subtraction. A clear borrow bit means the trial subtraction
            // succeeded, so keep the difference and record a quotient 1.
            // When the trial fails, the shifted value is below the divisor,
            // so it always fits in V bits.
            div_shift = {hi_q, lo_q[V-1]};
            div_diff  = div_shift - {1'b0, opnd_q};
            if (!div_diff[V]) begin
                hi_d = div_diff[V-1:0];
                lo_d = {lo_q[V-2:0], 1'b1};
            end else begin
                hi_d = div_shift[V-1:0];
                lo_d = {lo_q[V-2:0], 1'b0};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sign correction and result select (used in the final cycle)
    // -------------------------------------------------------------------------
    logic [2*V-1:0] prod_mag;
    logic [2*V-1:0] prod_signed;
    logic [V-1:0]   quo_signed;
    logic [V-1:0]   rem_signed;
    logic [V-1:0]   result_d;

    always_comb begin
        prod_mag    = {hi_q, lo_q};
        prod_signed = qneg_q ? (~prod_mag + 1'b1) : prod_mag;
        quo_signed  = qneg_q ? (~lo_q + 1'b1) : lo_q;
        // With a zero divisor, the loop leaves |src_a| in the remainder.
        // Giving it the dividend sign restores src_a exactly, as required.
        rem_signed  = rneg_q ? (~hi_q + 1'b1) : hi_q;
        result_d    = '0;
        case (op_q)
            3'b000:  result_d = prod_signed[V-1:0];
            3'b001,
            3'b010,
            3'b011:  result_d = prod_signed[2*V-1:V];
            3'b100,
            3'b101: begin
                if (dz_q)       result_d = '1;
                else if (ovf_q) result_d = {1'b1, {(V-1){1'b0}}};
                else            result_d = quo_signed;
            end
            default: begin
                if (ovf_q) result_d = '0;
                else       result_d = rem_signed;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments.
    // Every register then samples values from before the edge, whatever order
    // the statements appear in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q   <= md_ctrl;
                        qneg_q <= cap_a_neg ^ cap_b_neg;
                        rneg_q <= cap_a_neg;
                        dz_q   <= cap_dz;
                        ovf_q  <= cap_ovf;
                        hi_q   <= '0;
                        if (cap_is_div) begin
                            opnd_q <= cap_b_mag;
                            lo_q   <= cap_a_mag;
                        end else begin
                            opnd_q <= cap_a_mag;
                            lo_q   <= cap_b_mag;
                        end
                        cnt_q   <= CNT_W'(V);
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign md_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed bench for muldiv_unit. It applies a table of RV32M operations with
// hand-computed results. For each one it checks the value, the latency, the
// length of the busy window, that done is a single cycle, and that the result
// is held afterwards. Hand-written sequences cover three cases: start while
// busy, a back-to-back issue in the done cycle, and reset in the middle of an
// operation.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int V   = 32;
    localparam int LAT = V + 1;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   md_ctrl;
    logic [V-1:0] src_a;
    logic [V-1:0] src_b;
    logic         busy;
    logic         done;
    logic [V-1:0] md_result;

    int total;
    int bad;

    muldiv_unit #(.V(V)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_ctrl   (md_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .busy      (busy),
        .done      (done),
        .md_result (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [2:0] ctrl,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        vec_t v;
        v.name = name;
        v.ctrl = ctrl;
        v.a    = a;
        v.b    = b;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    // Drive start for one cycle. The task returns at the falling edge right
    // after the sampling edge (sample 0). At that point the operands are
    // scrambled, to show they matter only in the start cycle.
    task automatic issue(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start   = 1'b1;
        md_ctrl = ctrl;
        src_a   = a;
        src_b   = b;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        md_ctrl = 3'($urandom);
        src_a   = $urandom;
        src_b   = $urandom;
    endtask

    // Sample j is the falling edge after sampling edge k+j. The task returns
    // at the sample where done is seen, or done_at = -1 on timeout.
    task automatic wait_done(output logic [31:0] res, output int done_at, output int busy_cnt);
        res      = 'x;
        done_at  = -1;
        busy_cnt = 0;
        for (int j = 0; j < 3 * LAT; j++) begin
            if (j > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = j;
                res     = md_result;
                break;
            end
        end
    endtask

    logic [31:0] res;
    int          done_at;
    int          busy_cnt;
    int          done_cnt;

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        start   = 1'b0;
        md_ctrl = '0;
        src_a   = '0;
        src_b   = '0;

        // Reset state
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset md_result", md_result, 32'd0);
        #2 reset = 1'b0;

        // Vector table: funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
        //               100 DIV, 101 DIVU, 110 REM, 111 REMU
        add_vec("MUL 7*-3",        3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
        add_vec("MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        add_vec("MULHU max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        add_vec("MULHSU -1*2",     3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF);
        add_vec("MULH -1*-1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        add_vec("MULH -1*1",       3'b001, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF);
        add_vec("MULHU 2^16*2^16", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        add_vec("MUL 2^16*2^16",   3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        add_vec("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
        add_vec("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
        add_vec("DIV 7/-2",        3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD);
        add_vec("REM 7/-2",        3'b110, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001);
        add_vec("DIVU 100/7",      3'b101, 32'd100,      32'd7,        32'd14);
        add_vec("REMU 100/7",      3'b111, 32'd100,      32'd7,        32'd2);
        add_vec("DIVU min/max",    3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        add_vec("DIV 5/0",         3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF);
        add_vec("REM 5/0",         3'b110, 32'd5,        32'd0,        32'd5);
        add_vec("REM -7/0",        3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9);
        add_vec("DIVU -1/0",       3'b101, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF);
        add_vec("REMU -1/0",       3'b111, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF);
        add_vec("DIV min/-1",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        add_vec("REM min/-1",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        foreach (vecs[i]) begin
            issue(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            wait_done(res, done_at, busy_cnt);
            check({vecs[i].name, " result"}, res, vecs[i].exp);
            check({vecs[i].name, " latency"}, 32'(done_at), 32'(LAT));
            check({vecs[i].name, " busy cycles"}, 32'(busy_cnt), 32'(LAT));
            check({vecs[i].name, " busy in done cycle"}, 32'(busy), 32'd0);
            @(negedge clk);
            check({vecs[i].name, " done single cycle"}, 32'(done), 32'd0);
            check({vecs[i].name, " result held"}, md_result, vecs[i].exp);
        end

        // start while busy is ignored, then back-to-back issue in the done cycle
        issue(3'b000, 32'd6, 32'd7);
        done_cnt = 0;
        done_at  = -1;
        res      = 'x;
        for (int j = 0; j < 3 * LAT; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 10) begin
                start   = 1'b1;
                md_ctrl = 3'b101;
                src_a   = 32'd1000;
                src_b   = 32'd10;
            end else if (j == 11) begin
                start   = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_at = j;
                res     = md_result;
                break;
            end
        end
        check("ignored start: first result", res, 32'd42);
        check("ignored start: latency", 32'(done_at), 32'(LAT));
        check("ignored start: done count", 32'(done_cnt), 32'd1);
        // The unit is idle in the done cycle, so issue the next op right away.
        start   = 1'b1;
        md_ctrl = 3'b011;
        src_a   = 32'h0001_0000;
        src_b   = 32'h0003_0000;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        src_a   = '0;
        src_b   = '0;
        check("b2b: no consecutive done", 32'(done), 32'd0);
        check("b2b: busy after issue", 32'(busy), 32'd1);
        wait_done(res, done_at, busy_cnt);
        check("b2b: result", res, 32'd3);
        check("b2b: latency", 32'(done_at), 32'(LAT));

        // Reset in the middle of a DIV
        issue(3'b100, 32'd1000, 32'd7);
        repeat (15) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset done", 32'(done), 32'd0);
        check("async reset md_result", md_result, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        done_cnt = 0;
        for (int j = 0; j < 2 * LAT; j++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("reset: no done afterwards", 32'(done_cnt), 32'd0);
        issue(3'b000, 32'd3, 32'd4);
        wait_done(res, done_at, busy_cnt);
        check("post-reset MUL 3*4", res, 32'd12);
        check("post-reset latency", 32'(done_at), 32'(LAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit for the RV32M instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle integer ALU in the execute stage and acts as the responder to the core's issue logic. The core issues an operation with a one-cycle start pulse, stalls on busy, and picks up the registered result on the done pulse. Latency is constant for every operation and operand value.

## Interface
Parameters:
- V, 32, datapath width; only V=32 is supported and verified.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  issue strobe; sampled only while the unit is idle.
- md_ctrl  input  3  operation select, equal to RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  input  V  rs1 operand (multiplicand / dividend).
- src_b  input  V  rs2 operand (multiplier / divisor).
- busy  output  1  high while an operation is in flight; the core stalls issue while it is high.
- done  output  1  one-cycle pulse; md_result is valid from this cycle onward.
- md_result  output  V  registered result; holds its value until the next done pulse.

## Operation
- States:
  - IDLE: start=1 captures md_ctrl, sign flags, and absolute values of the operands; next state RUN. Absolute values are taken only for signed operands: MULH takes both, MULHSU takes src_a only, DIV/REM take both.
  - RUN: performs one iteration per cycle for V cycles. An iteration counter loads V and decrements; when it reaches 1, next state is FIN.
  - FIN: applies sign correction, writes md_result, pulses done; next state IDLE.
- Multiply:
  - Unsigned shift-add over a 2V-bit product register.
  - The product is negated when the operand signs differ.
  - MUL returns the low V bits; MULH, MULHSU and MULHU return the high V bits of the signed or unsigned 2V-bit product.
- Divide:
  - Restoring divide on magnitudes, using a V+1-bit partial remainder.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Special cases (detected at capture, applied in FIN, full latency still taken):
  - Divisor 0: quotient = all ones; remainder = src_a unmodified (signed and unsigned alike).
  - Signed overflow (src_a=0x80000000, src_b=0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- start while busy=1 is ignored; the in-flight operation is unaffected.
- Operands and md_ctrl need to be valid only in the start cycle; later changes have no effect.

## Timing
- Reset values: state IDLE, busy=0, done=0, md_result=0, counter=0.
- Latency for start sampled at edge k:
  - busy=1 in the cycles following edges k through k+V.
  - done=1 and md_result valid in the cycle following edge k+V+1, i.e. V+1 cycles after issue (33 for V=32).
  - busy=0 in that same cycle.
- Back-to-back: start may be asserted in the done cycle (state IDLE) and is accepted, giving one result every V+2 cycles at maximum throughput.
- done is never high for two consecutive cycles.
- Reset asserted mid-operation:
  - Outputs return to reset values immediately (asynchronous).
  - The operation is discarded with no done pulse.
  - The first start after reset deassertion behaves normally.
- busy and done are driven from registered state only; neither has a combinational path from start.

## Test plan
- MUL src_a=7, src_b=0xFFFFFFFD (-3) -> done at start+33 cycles, md_result=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD.
- REM -7/2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14.
- REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU -1/0 -> 0xFFFFFFFF. DIV 0x80000000/-1 -> 0x80000000; REM of the same operands -> 0.
- Pulse start again 10 cycles into an operation with different operands -> first result unchanged, no extra done. Then issue a new start in the done cycle -> accepted, its done arrives 33 cycles later.
- Assert reset at cycle 15 of a DIV -> busy=0, done=0, md_result=0 immediately, no done afterwards. A fresh MUL 3x4 after reset -> 12.
